cmd_frame_encoder: RTL and testbench

//  Transmit-side counterpart of the command frame parser: serialises one command
//  (cmd, len, payload) into a framed byte stream AA 55 CMD LEN_H LEN_L PAYLOAD[len] CSUM.

---
 rtl/cmd_frame_encoder.sv | 170 +++++++++++++++++
 tb/tb_cmd_frame_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_encoder.sv
// rtl/cmd_frame_encoder.sv - serialises cmd/len/payload into an AA 55 CMD LEN_H LEN_L PAYLOAD CSUM byte stream
module cmd_frame_encoder #(
  parameter int         MAX_LEN = 1024,
  parameter logic [7:0] HDR_H   = 8'hAA,
  parameter logic [7:0] HDR_L   = 8'h55,
  parameter int         MIN_GAP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  cmd_i,
  input  logic [15:0] len_i,
  input  logic        abort_i,
  input  logic [7:0]  pl_data_i,
  input  logic        pl_valid_i,
  output logic        pl_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int              GW        = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GW-1:0]   GAP_INIT  = GW'(MIN_GAP - 1);
  localparam logic [16:0]     MAX_LEN_W = 17'(MAX_LEN);

  typedef enum logic [3:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_CMD, ST_LENH, ST_LENL, ST_PAYLOAD, ST_CSUM, ST_GAP
  } state_t;

  state_t        state_q, ret_q, ret_d;
  logic [7:0]    cmd_q, csum_q, csum_d, out_data_q, gap_byte_d;
  logic [15:0]   len_q, remaining_q;
  logic [GW-1:0] gap_q;
  logic          out_valid_q, pl_ready_q, busy_q, done_q, error_q;
  logic          hs;

  assign hs     = out_valid_q & out_ready_i;
  assign csum_d = csum_q + out_data_q;

  // Which byte state follows the one whose byte is being accepted now.
  always_comb begin
    ret_d = ST_IDLE;
    case (state_q)
      ST_HDR0:    ret_d = ST_HDR1;
      ST_HDR1:    ret_d = ST_CMD;
      ST_CMD:     ret_d = ST_LENH;
      ST_LENH:    ret_d = ST_LENL;
      ST_LENL:    ret_d = (len_q == 16'd0) ? ST_CSUM : ST_PAYLOAD;
      ST_PAYLOAD: ret_d = (remaining_q == 16'd1) ? ST_CSUM : ST_PAYLOAD;
      default:    ret_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gap_byte_d = 8'h00;
    case (ret_q)
      ST_HDR1: gap_byte_d = HDR_L;
      ST_CMD:  gap_byte_d = cmd_q;
      ST_LENH: gap_byte_d = len_q[15:8];
      ST_LENL: gap_byte_d = len_q[7:0];
      ST_CSUM: gap_byte_d = csum_q;
      default: gap_byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      cmd_q       <= 8'h00;
      len_q       <= 16'd0;
      remaining_q <= 16'd0;
      csum_q      <= 8'h00;
      gap_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (abort_i) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
        pl_ready_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
            // busy is still high during the done cycle, so start is only honoured afterwards
            if (start_i && !done_q) begin
              if ({1'b0, len_i} > MAX_LEN_W) begin
                error_q <= 1'b1;
              end else begin
                cmd_q       <= cmd_i;
                len_q       <= len_i;
                remaining_q <= len_i;
                csum_q      <= 8'h00;
                busy_q      <= 1'b1;
                out_data_q  <= HDR_H;
                out_valid_q <= 1'b1;
                state_q     <= ST_HDR0;
              end
            end
          end
          ST_GAP: begin
            if (gap_q == '0) begin
              state_q <= ret_q;
              if (ret_q == ST_PAYLOAD) begin
                pl_ready_q <= 1'b1;
              end else begin
                out_data_q  <= gap_byte_d;
                out_valid_q <= 1'b1;
              end
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          ST_PAYLOAD: begin
            if (!out_valid_q) begin
              if (pl_valid_i && pl_ready_q) begin
                out_data_q  <= pl_data_i;
                out_valid_q <= 1'b1;
                pl_ready_q  <= 1'b0;
              end
            end else if (hs) begin
              csum_q      <= csum_d;
              remaining_q <= remaining_q - 16'd1;
              out_valid_q <= 1'b0;
              ret_q       <= ret_d;
              gap_q       <= GAP_INIT;
              state_q     <= ST_GAP;
            end
          end
          ST_CSUM: begin
            if (hs) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            if (hs) begin
              // header bytes are excluded from the checksum
              if (state_q != ST_HDR0 && state_q != ST_HDR1) csum_q <= csum_d;
              out_valid_q <= 1'b0;
              ret_q       <= ret_d;
              gap_q       <= GAP_INIT;
              state_q     <= ST_GAP;
            end
          end
        endcase
      end
    end
  end

  assign pl_ready_o  = pl_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_cmd_frame_encoder.sv
// tb/tb_cmd_frame_encoder.sv - self-checking bench for cmd_frame_encoder (MIN_GAP 1 and 3 instances)
module tb_cmd_frame_encoder;

  localparam int MAXL = 1024;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, abort, pl_valid, out_ready;
  logic [1:0] pl_ready, out_valid, busy, done, error;
  logic [7:0] cmd [2];
  logic [7:0] pl_data [2];
  logic [7:0] out_data [2];
  logic [15:0] len [2];

  cmd_frame_encoder #(.MIN_GAP(1)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .cmd_i(cmd[0]), .len_i(len[0]),
    .abort_i(abort[0]), .pl_data_i(pl_data[0]), .pl_valid_i(pl_valid[0]), .pl_ready_o(pl_ready[0]),
    .out_data_o(out_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]));

  cmd_frame_encoder #(.MIN_GAP(3)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .cmd_i(cmd[1]), .len_i(len[1]),
    .abort_i(abort[1]), .pl_data_i(pl_data[1]), .pl_valid_i(pl_valid[1]), .pl_ready_o(pl_ready[1]),
    .out_data_o(out_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] pay [MAXL];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Drives one frame on instance i and checks the emitted stream against the frame rules.
  task automatic run_frame(input int i, input logic [7:0] c, input int n, input bit rr, input bit rv,
                           input int stall_at, input int abort_at, input int rst_at, input bit sid,
                           output logic [7:0] last_byte);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int sum, pidx, low, stall_left, cyc, mode, quiet;
    bit fin, lowp;
    exp_q = {};
    got_q = {};
    sum = c + (n / 256) + (n % 256);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(c);
    exp_q.push_back(8'(n / 256));
    exp_q.push_back(8'(n % 256));
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(pay[k]);
      sum += pay[k];
    end
    exp_q.push_back(8'(sum % 256));
    last_byte = 8'h00;

    @(negedge clk);
    start[i] = 1'b1; cmd[i] = c; len[i] = 16'(n);
    @(negedge clk);
    start[i] = 1'b0;
    chk("first_valid", {31'd0, out_valid[i]}, 1);
    chk("first_byte", {24'd0, out_data[i]}, 32'hAA);
    chk("busy_on", {31'd0, busy[i]}, 1);

    pidx = 0; low = 0; lowp = 0; stall_left = 5; cyc = 0; mode = 0; fin = 0;
    while (!fin && cyc < 20000) begin
      if (done[i]) begin
        chk("busy_in_done", {31'd0, busy[i]}, 1);
        if (sid) begin start[i] = 1'b1; cmd[i] = 8'h5A; len[i] = 16'd0; end
        fin = 1;
      end else if (abort_at >= 0 && pidx == abort_at) begin
        abort[i] = 1'b1; mode = 1; fin = 1;
      end else if (rst_at >= 0 && got_q.size() == rst_at) begin
        rst[i] = 1'b1; mode = 2; fin = 1;
      end else begin
        if (out_valid[i] && lowp) begin
          if (got_q.size() >= 5 && got_q.size() < 5 + n)
            chk("gap_min", {31'd0, low >= gap_of(i)}, 1);
          else
            chk("gap_exact", low, gap_of(i));
          lowp = 0;
        end else if (!out_valid[i] && lowp) begin
          low++;
        end
        if (pl_ready[i]) begin
          chk("pl_ready_ovalid", {31'd0, out_valid[i]}, 0);
          chk("pl_ready_in_range", {31'd0, pidx < n}, 1);
        end
        pl_valid[i] = rv ? 1'($urandom_range(0, 1)) : 1'b1;
        pl_data[i]  = (pidx < n) ? pay[pidx] : 8'h00;
        if (out_valid[i] && got_q.size() == stall_at && stall_left > 0) begin
          out_ready[i] = 1'b0;
          stall_left--;
          chk("stall_data", {24'd0, out_data[i]}, {24'd0, exp_q[stall_at]});
        end else begin
          out_ready[i] = rr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_valid[i] && out_ready[i]) begin
          got_q.push_back(out_data[i]);
          low = 0; lowp = 1;
        end
        if (pl_ready[i] && pl_valid[i]) pidx++;
        @(negedge clk);
        cyc++;
      end
    end

    pl_valid[i] = 1'b0;
    if (!fin) begin
      chk("timeout", 0, 1);
    end else if (mode != 0) begin
      @(negedge clk);
      abort[i] = 1'b0; rst[i] = 1'b0;
      chk("kill_out_valid", {31'd0, out_valid[i]}, 0);
      chk("kill_pl_ready", {31'd0, pl_ready[i]}, 0);
      chk("kill_busy", {31'd0, busy[i]}, 0);
      chk("kill_done", {31'd0, done[i]}, 0);
      if (mode == 2) begin
        chk("rst_out_data", {24'd0, out_data[i]}, 0);
        chk("rst_error", {31'd0, error[i]}, 0);
      end
      quiet = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid[i] || done[i] || busy[i]) quiet++;
      end
      chk("quiet_after_kill", quiet, 0);
    end else begin
      @(negedge clk);
      start[i] = 1'b0;
      chk("busy_off", {31'd0, busy[i]}, 0);
      chk("done_single", {31'd0, done[i]}, 0);
      if (sid) begin
        chk("start_in_done_ignored", {31'd0, out_valid[i]}, 0);
        @(negedge clk);
        chk("no_late_start", {31'd0, out_valid[i] | busy[i]}, 0);
      end
      if (stall_at >= 0 && stall_at < exp_q.size()) chk("stall_len", stall_left, 0);
      chk("frame_len", got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        chk("frame_byte", {24'd0, got_q[k]}, {24'd0, exp_q[k]});
      chk("pay_consumed", pidx, n);
      if (got_q.size() > 0) last_byte = got_q[got_q.size() - 1];
    end
  endtask

  task automatic err_test(input int i);
    @(negedge clk);
    start[i] = 1'b1; cmd[i] = 8'h33; len[i] = 16'd1025;
    @(negedge clk);
    start[i] = 1'b0;
    chk("err_pulse", {31'd0, error[i]}, 1);
    chk("err_busy", {31'd0, busy[i]}, 0);
    chk("err_out_valid", {31'd0, out_valid[i]}, 0);
    @(negedge clk);
    chk("err_single", {31'd0, error[i]}, 0);
    chk("err_quiet", {31'd0, out_valid[i]}, 0);
  endtask

  typedef struct {
    logic [7:0]  c;
    int          n;
    logic [31:0] p;
    logic [7:0]  csum;
    int          inst;
    int          stall;
  } vec_t;

  vec_t tv [5];
  logic [7:0] lb;

  initial begin
    tv[0] = '{8'h01, 2, 32'h1234_0000, 8'h49, 0, -1};
    tv[1] = '{8'hFD, 0, 32'h0000_0000, 8'hFD, 0, -1};
    tv[2] = '{8'hFF, 1, 32'hFF00_0000, 8'hFF, 1, -1};
    tv[3] = '{8'h01, 2, 32'h1234_0000, 8'h49, 1, 3};
    tv[4] = '{8'h10, 3, 32'h0102_0300, 8'h19, 0, 3};

    rst = 2'b11; start = 2'b00; abort = 2'b00; pl_valid = 2'b00; out_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin cmd[i] = 8'h00; len[i] = 16'd0; pl_data[i] = 8'h00; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_out_valid", {31'd0, out_valid[i]}, 0);
      chk("reset_out_data", {24'd0, out_data[i]}, 0);
      chk("reset_pl_ready", {31'd0, pl_ready[i]}, 0);
      chk("reset_busy", {31'd0, busy[i]}, 0);
      chk("reset_done", {31'd0, done[i]}, 0);
      chk("reset_error", {31'd0, error[i]}, 0);
    end
    rst = 2'b00;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 4; k++) pay[k] = tv[t].p[31 - 8 * k -: 8];
      run_frame(tv[t].inst, tv[t].c, tv[t].n, 1'b0, 1'b0, tv[t].stall, -1, -1, 1'b0, lb);
      chk("table_csum", {24'd0, lb}, {24'd0, tv[t].csum});
    end

    for (int i = 0; i < 2; i++) begin
      err_test(i);
      pay[0] = 8'hA5;
      run_frame(i, 8'h42, 1, 1'b0, 1'b0, -1, -1, -1, 1'b0, lb);
    end

    for (int r = 0; r < 12; r++) begin
      int n, st;
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) pay[k] = 8'($urandom);
      st = (r % 3 == 0) ? $urandom_range(0, 5 + n) : -1;
      run_frame(r % 2, 8'($urandom), n, 1'b1, 1'b1, st, -1, -1, 1'b0, lb);
    end

    for (int k = 0; k < MAXL; k++) pay[k] = 8'($urandom);
    run_frame(0, 8'hC3, MAXL, 1'b0, 1'b0, -1, -1, -1, 1'b0, lb);

    for (int k = 0; k < 4; k++) pay[k] = 8'(8'h20 + k);
    run_frame(0, 8'h77, 4, 1'b0, 1'b0, -1, 1, -1, 1'b0, lb);
    run_frame(1, 8'h78, 4, 1'b0, 1'b0, -1, -1, 3, 1'b0, lb);
    run_frame(0, 8'h79, 4, 1'b0, 1'b0, -1, -1, -1, 1'b1, lb);
    run_frame(1, 8'h7A, 4, 1'b1, 1'b0, -1, -1, -1, 1'b0, lb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
